// File: rtl/mini_cpu_pkg.sv
// Shared opcodes, FSM state encoding and immediate decoding for mini_cpu_core.
package mini_cpu_pkg;

  localparam logic [2:0] OP_LOAD    = 3'd0;
  localparam logic [2:0] OP_ADD     = 3'd1;
  localparam logic [2:0] OP_ADDI    = 3'd2;
  localparam logic [2:0] OP_SUB     = 3'd3;
  localparam logic [2:0] OP_SUBI    = 3'd4;
  localparam logic [2:0] OP_MUL     = 3'd5;
  localparam logic [2:0] OP_CLEAR   = 3'd6;
  localparam logic [2:0] OP_DISPLAY = 3'd7;

  typedef enum logic [2:0] {S_IDLE, S_EXEC, S_MUL, S_CLR, S_WB} state_t;

  // Sign-magnitude to two's complement; a negative zero folds to 0. Caller truncates.
  function automatic logic [31:0] sm_to_tc(input logic sign, input logic [31:0] mag);
    return sign ? (~mag + 32'd1) : mag;
  endfunction

endpackage

// File: rtl/mini_cpu_seq_mul.sv
// Shift-add multiplier on operand magnitudes: start loads, then DATA_W iterations run.
// done flags the last iteration, with prod/sign valid in that same cycle; never stalls.
module mini_cpu_seq_mul #(
  parameter int DATA_W = 16
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  start,
  input  logic [DATA_W-1:0]     op_a,
  input  logic [DATA_W-1:0]     op_b,
  output logic                  done,
  output logic [2*DATA_W-1:0]   prod,
  output logic                  sign
);

  localparam int CW = $clog2(DATA_W + 1);

  logic [2*DATA_W-1:0] mcand;
  logic [2*DATA_W-1:0] acc;
  logic [DATA_W-1:0]   mplier;
  logic [CW-1:0]       cnt;
  logic [DATA_W-1:0]   mag_a;
  logic [DATA_W-1:0]   mag_b;

  assign mag_a = op_a[DATA_W-1] ? -op_a : op_a;
  assign mag_b = op_b[DATA_W-1] ? -op_b : op_b;

  // Exposing the accumulator plus the current partial product lets the core
  // consume the full product in the final iteration cycle.
  assign prod = acc + (mplier[0] ? mcand : '0);
  assign done = (cnt == CW'(1));

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      mcand  <= '0;
      acc    <= '0;
      mplier <= '0;
      cnt    <= '0;
      sign   <= 1'b0;
    end else if (start) begin
      mcand  <= {{DATA_W{1'b0}}, mag_a};
      mplier <= mag_b;
      acc    <= '0;
      cnt    <= CW'(DATA_W);
      sign   <= op_a[DATA_W-1] ^ op_b[DATA_W-1];
    end else if (cnt != '0) begin
      acc    <= prod;
      mcand  <= mcand << 1;
      mplier <= mplier >> 1;
      cnt    <= cnt - CW'(1);
    end
  end

endmodule

// File: rtl/mini_cpu_core.sv
// Register-file CPU running one opcode per synced enviar press; done at T+2 (MUL T+DATA_W+1, CLEAR T+NREGS+1).
// Presses while busy or with ligar low are dropped via cmd_ignored; MINI_CPU_SAT_EN saturates on overflow.
module mini_cpu_core import mini_cpu_pkg::*; #(
  parameter int DATA_W = 16,
  parameter int NREGS  = 16,
  parameter int ADDR_W = $clog2(NREGS),
  parameter int IMM_W  = 7
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              ligar,
  input  logic              enviar,
  input  logic [2:0]        opcode,
  input  logic [ADDR_W-1:0] addr1,
  input  logic [ADDR_W-1:0] addr2,
  input  logic [IMM_W-1:0]  addr3_imm,
  output logic              busy,
  output logic              done,
  output logic [DATA_W-1:0] res_data,
  output logic [ADDR_W-1:0] res_addr,
  output logic [2:0]        res_op,
  output logic              ovf,
  output logic              cmd_ignored
);

  localparam logic [DATA_W-1:0] MAX_V = {1'b0, {(DATA_W-1){1'b1}}};
  localparam logic [DATA_W-1:0] MIN_V = {1'b1, {(DATA_W-1){1'b0}}};

  logic ligar_m, ligar_s, enviar_m, enviar_s, enviar_q;
  state_t              state;
  logic [2:0]          op_q;
  logic [ADDR_W-1:0]   a1_q, a2_q, clr_idx;
  logic [IMM_W-1:0]    imm_q;
  logic [DATA_W-1:0]   regs [NREGS];
  logic                press, accept, abort, wr_en;
  logic [DATA_W-1:0]   imm_val, opa, opb, alu_res, mul_res;
  logic [DATA_W:0]     sum_ext;
  logic                alu_ovf, mul_ovf, is_sub;
  logic                mul_start, mul_done, mul_sign;
  logic [2*DATA_W-1:0] mul_prod;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      {ligar_m, ligar_s, enviar_m, enviar_s, enviar_q} <= '0;
    end else begin
      ligar_m  <= ligar;
      ligar_s  <= ligar_m;
      enviar_m <= enviar;
      enviar_s <= enviar_m;
      enviar_q <= enviar_s;
    end
  end

  assign press     = enviar_s & ~enviar_q;
  assign accept    = press && ligar_s && (state == S_IDLE);
  // WB is not abortable: done and res_* were already committed on entry.
  assign abort     = !ligar_s && (state == S_EXEC || state == S_MUL || state == S_CLR);
  assign imm_val   = DATA_W'(sm_to_tc(imm_q[IMM_W-1], 32'(imm_q[IMM_W-2:0])));
  assign mul_start = accept && (opcode == OP_MUL);
  assign wr_en     = (state == S_WB) && (op_q != OP_DISPLAY) && (op_q != OP_CLEAR);

  always_comb begin
    opa     = regs[a2_q];
    opb     = (op_q == OP_ADDI || op_q == OP_SUBI) ? imm_val : regs[imm_q[IMM_W-1 -: ADDR_W]];
    is_sub  = (op_q == OP_SUB || op_q == OP_SUBI);
    sum_ext = is_sub ? ({opa[DATA_W-1], opa} - {opb[DATA_W-1], opb})
                     : ({opa[DATA_W-1], opa} + {opb[DATA_W-1], opb});
    alu_ovf = 1'b0;
    alu_res = sum_ext[DATA_W-1:0];
    case (op_q)
      OP_LOAD:                          alu_res = imm_val;
      OP_DISPLAY:                       alu_res = regs[a1_q];
      OP_ADD, OP_ADDI, OP_SUB, OP_SUBI: alu_ovf = sum_ext[DATA_W] ^ sum_ext[DATA_W-1];
      default:                          alu_res = sum_ext[DATA_W-1:0];
    endcase
`ifdef MINI_CPU_SAT_EN
    if (alu_ovf) alu_res = sum_ext[DATA_W] ? MIN_V : MAX_V;
`endif
  end

  mini_cpu_seq_mul #(.DATA_W(DATA_W)) u_mul (
    .clk   (clk),
    .rst   (rst),
    .start (mul_start),
    .op_a  (regs[addr2]),
    .op_b  (regs[addr3_imm[IMM_W-1 -: ADDR_W]]),
    .done  (mul_done),
    .prod  (mul_prod),
    .sign  (mul_sign)
  );

  // A negative product may reach exactly 2^(DATA_W-1) and still fit.
  always_comb begin
    mul_ovf = mul_sign ? (mul_prod > {{DATA_W{1'b0}}, MIN_V})
                       : (mul_prod > {{DATA_W{1'b0}}, MAX_V});
    mul_res = mul_sign ? -mul_prod[DATA_W-1:0] : mul_prod[DATA_W-1:0];
`ifdef MINI_CPU_SAT_EN
    if (mul_ovf) mul_res = mul_sign ? MIN_V : MAX_V;
`endif
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state       <= S_IDLE;
      op_q        <= '0;
      a1_q        <= '0;
      a2_q        <= '0;
      imm_q       <= '0;
      clr_idx     <= '0;
      busy        <= 1'b0;
      done        <= 1'b0;
      cmd_ignored <= 1'b0;
      ovf         <= 1'b0;
      res_data    <= '0;
      res_addr    <= '0;
      res_op      <= '0;
    end else begin
      done        <= 1'b0;
      cmd_ignored <= press && !accept;
      if (abort) begin
        state <= S_IDLE;
        busy  <= 1'b0;
      end else begin
        case (state)
          S_IDLE: if (accept) begin
            op_q    <= opcode;
            a1_q    <= addr1;
            a2_q    <= addr2;
            imm_q   <= addr3_imm;
            clr_idx <= '0;
            busy    <= 1'b1;
            state   <= (opcode == OP_MUL) ? S_MUL : (opcode == OP_CLEAR) ? S_CLR : S_EXEC;
          end
          S_EXEC: begin
            state    <= S_WB;
            done     <= 1'b1;
            res_data <= alu_res;
            res_addr <= a1_q;
            res_op   <= op_q;
            ovf      <= alu_ovf;
          end
          S_MUL: if (mul_done) begin
            state    <= S_WB;
            done     <= 1'b1;
            res_data <= mul_res;
            res_addr <= a1_q;
            res_op   <= op_q;
            ovf      <= mul_ovf;
          end
          S_CLR: begin
            clr_idx <= clr_idx + ADDR_W'(1);
            if (clr_idx == ADDR_W'(NREGS - 1)) begin
              state    <= S_WB;
              done     <= 1'b1;
              res_data <= '0;
              res_addr <= '0;
              res_op   <= op_q;
              ovf      <= 1'b0;
            end
          end
          S_WB: begin
            state <= S_IDLE;
            busy  <= 1'b0;
          end
          default: state <= S_IDLE;
        endcase
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < NREGS; i++) regs[i] <= '0;
    end else if (state == S_CLR && !abort) begin
      regs[clr_idx] <= '0;
    end else if (wr_en) begin
      regs[a1_q] <= res_data;
    end
  end

endmodule

// File: tb/tb_mini_cpu_core.sv
// Directed vector bench for mini_cpu_core (default parameters, 2-flop input sync).
module tb_mini_cpu_core;
  import mini_cpu_pkg::*;

  logic        clk = 1'b0;
  logic        rst, ligar, enviar;
  logic [2:0]  opcode;
  logic [3:0]  addr1, addr2;
  logic [6:0]  addr3_imm;
  logic        busy, done, ovf, cmd_ignored;
  logic [15:0] res_data;
  logic [3:0]  res_addr;
  logic [2:0]  res_op;

  mini_cpu_core dut (
    .clk(clk), .rst(rst), .ligar(ligar), .enviar(enviar), .opcode(opcode),
    .addr1(addr1), .addr2(addr2), .addr3_imm(addr3_imm), .busy(busy), .done(done),
    .res_data(res_data), .res_addr(res_addr), .res_op(res_op), .ovf(ovf),
    .cmd_ignored(cmd_ignored)
  );

  always #5 clk = ~clk;

  // Press driven after edge P0 is synced by P2, accepted in the following cycle T.
  localparam int SYNC = 2;

`ifdef MINI_CPU_SAT_EN
  localparam logic [15:0] R7V = 16'h7FFF, R12V = 16'h7FFF, R13V = 16'h7FFF;
`else
  localparam logic [15:0] R7V = 16'hD0BF, R12V = 16'h5F01, R13V = 16'hBE02;
`endif

  typedef struct {
    logic [2:0]  op;
    logic [3:0]  a1, a2;
    logic [6:0]  imm;
    logic [15:0] exp;
    logic        eovf;
    int          lat;
  } vec_t;

  vec_t tv [16];
  int n_cmp = 0, n_bad = 0;
  int done_at, busy_at, busy_cnt, n_done, n_ign;
  logic [15:0] got_data;
  logic [3:0]  got_addr;
  logic [2:0]  got_op;
  logic        got_ovf;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h, want 0x%0h", name, act, exp);
    end
  endtask

  task automatic issue(input logic [2:0] op, input logic [3:0] a1, input logic [3:0] a2,
                       input logic [6:0] imm);
    opcode = op; addr1 = a1; addr2 = a2; addr3_imm = imm;
    enviar = 1'b1;
    done_at = -1; busy_at = -1; busy_cnt = 0;
    for (int n = 1; n <= 60 && done_at < 0; n++) begin
      @(posedge clk); #1;
      if (n == 3) enviar = 1'b0;
      if (busy) busy_cnt++;
      if (busy && busy_at < 0) busy_at = n;
      if (done) begin
        done_at = n;
        got_data = res_data; got_addr = res_addr; got_op = res_op; got_ovf = ovf;
      end
    end
    enviar = 1'b0;
    repeat (4) @(posedge clk);
    #1;
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    tv[0]  = '{OP_LOAD,    4'd1,  4'd0,  7'h05, 16'h0005, 1'b0, 2};
    tv[1]  = '{OP_LOAD,    4'd2,  4'd0,  7'h43, 16'hFFFD, 1'b0, 2};
    tv[2]  = '{OP_ADD,     4'd3,  4'd1,  7'h10, 16'h0002, 1'b0, 2};
    tv[3]  = '{OP_DISPLAY, 4'd3,  4'd0,  7'h00, 16'h0002, 1'b0, 2};
    tv[4]  = '{OP_MUL,     4'd4,  4'd1,  7'h10, 16'hFFF1, 1'b0, 17};
    tv[5]  = '{OP_LOAD,    4'd5,  4'd0,  7'h3F, 16'h003F, 1'b0, 2};
    tv[6]  = '{OP_MUL,     4'd6,  4'd5,  7'h28, 16'h0F81, 1'b0, 17};
    tv[7]  = '{OP_MUL,     4'd7,  4'd6,  7'h28, R7V,      1'b1, 17};
    tv[8]  = '{OP_ADDI,    4'd8,  4'd2,  7'h40, 16'hFFFD, 1'b0, 2};
    tv[9]  = '{OP_SUBI,    4'd9,  4'd1,  7'h07, 16'hFFFE, 1'b0, 2};
    tv[10] = '{OP_MUL,     4'd12, 4'd6,  7'h30, R12V,     1'b1, 17};
    tv[11] = '{OP_ADD,     4'd13, 4'd12, 7'h60, R13V,     1'b1, 2};
    tv[12] = '{OP_SUB,     4'd3,  4'd3,  7'h18, 16'h0000, 1'b0, 2};
    tv[13] = '{OP_MUL,     4'd14, 4'd2,  7'h10, 16'h0009, 1'b0, 17};
    tv[14] = '{OP_DISPLAY, 4'd7,  4'd0,  7'h00, R7V,      1'b0, 2};
    tv[15] = '{OP_DISPLAY, 4'd13, 4'd0,  7'h00, R13V,     1'b0, 2};

    rst = 1'b1; ligar = 1'b1; enviar = 1'b0;
    opcode = '0; addr1 = '0; addr2 = '0; addr3_imm = '0;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_busy", busy, 0);
    chk("rst_done", done, 0);
    chk("rst_ovf", ovf, 0);
    chk("rst_ign", cmd_ignored, 0);
    chk("rst_data", res_data, 0);
    chk("rst_addr", res_addr, 0);
    chk("rst_op", res_op, 0);
    rst = 1'b0;
    repeat (4) @(posedge clk);
    #1;

    for (int i = 0; i < 16; i++) begin
      issue(tv[i].op, tv[i].a1, tv[i].a2, tv[i].imm);
      chk($sformatf("v%0d_done_at", i), done_at, SYNC + tv[i].lat);
      chk($sformatf("v%0d_busy_at", i), busy_at, SYNC + 1);
      chk($sformatf("v%0d_busy_len", i), busy_cnt, tv[i].lat);
      chk($sformatf("v%0d_data", i), got_data, tv[i].exp);
      chk($sformatf("v%0d_addr", i), got_addr, tv[i].a1);
      chk($sformatf("v%0d_op", i), got_op, tv[i].op);
      chk($sformatf("v%0d_ovf", i), got_ovf, tv[i].eovf);
    end

    // Second press during a MUL is dropped; only the MUL completes.
    opcode = OP_MUL; addr1 = 4'd15; addr2 = 4'd1; addr3_imm = 7'h10;
    enviar = 1'b1; n_done = 0; n_ign = 0; done_at = -1;
    for (int n = 1; n <= 40; n++) begin
      @(posedge clk); #1;
      if (n == 3) enviar = 1'b0;
      if (n == 8) begin opcode = OP_LOAD; addr1 = 4'd0; addr3_imm = 7'h05; enviar = 1'b1; end
      if (n == 11) enviar = 1'b0;
      if (done) begin n_done++; done_at = n; end
      if (cmd_ignored) n_ign++;
    end
    chk("busy_press_ign", n_ign, 1);
    chk("busy_press_dones", n_done, 1);
    chk("busy_press_done_at", done_at, SYNC + 17);
    chk("busy_press_addr", res_addr, 15);
    chk("busy_press_data", res_data, 16'hFFF1);

    // ligar drop mid-MUL aborts; a press while off is dropped.
    opcode = OP_MUL; addr1 = 4'd4; addr2 = 4'd5; addr3_imm = 7'h28;
    enviar = 1'b1; n_done = 0; n_ign = 0;
    for (int n = 1; n <= 30; n++) begin
      @(posedge clk); #1;
      if (n == 3) enviar = 1'b0;
      if (n == 7) begin
        chk("abort_busy_before", busy, 1);
        ligar = 1'b0;
      end
      if (n == 10) chk("abort_busy_after", busy, 0);
      if (n == 14) enviar = 1'b1;
      if (n == 17) enviar = 1'b0;
      if (done) n_done++;
      if (cmd_ignored) n_ign++;
    end
    chk("abort_dones", n_done, 0);
    chk("abort_off_ign", n_ign, 1);
    chk("abort_res_addr", res_addr, 15);
    chk("abort_res_data", res_data, 16'hFFF1);
    ligar = 1'b1;
    repeat (4) @(posedge clk);
    #1;
    issue(OP_DISPLAY, 4'd4, 4'd0, 7'h00);
    chk("abort_dest_kept", got_data, 16'hFFF1);

    issue(OP_CLEAR, 4'd9, 4'd9, 7'h48);
    chk("clr_done_at", done_at, SYNC + 17);
    chk("clr_data", got_data, 0);
    chk("clr_addr", got_addr, 0);
    chk("clr_op", got_op, OP_CLEAR);
    chk("clr_ovf", got_ovf, 0);
    for (int r = 0; r < 16; r++) begin
      issue(OP_DISPLAY, 4'(r), 4'd0, 7'h00);
      chk($sformatf("clr_r%0d", r), got_data, 0);
    end

    // Async reset in the middle of a CLEAR.
    issue(OP_ADDI, 4'd15, 4'd0, 7'h05);
    chk("pre_rst_data", got_data, 16'h0005);
    opcode = OP_CLEAR; enviar = 1'b1;
    for (int n = 1; n <= 10; n++) begin
      @(posedge clk); #1;
      if (n == 3) enviar = 1'b0;
    end
    chk("mid_clr_busy", busy, 1);
    #1 rst = 1'b1;
    #1;
    chk("arst_busy", busy, 0);
    chk("arst_done", done, 0);
    chk("arst_data", res_data, 0);
    chk("arst_addr", res_addr, 0);
    chk("arst_op", res_op, 0);
    @(posedge clk); #1;
    rst = 1'b0;
    repeat (4) @(posedge clk);
    #1;
    issue(OP_DISPLAY, 4'd15, 4'd0, 7'h00);
    chk("arst_r15", got_data, 0);
    chk("arst_r15_done_at", done_at, SYNC + 2);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
